md_sched: RTL
=============

MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MUL_LAT, default 5, SHALL set the number of busy cycles for mult/multu.
REQ-002 Parameter DIV_LAT, default 10, SHALL set the number of busy cycles for div/divu.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 start  input  1  SHALL be high when E stage presents a multiply/divide-class op this cycle.
REQ-006 op  input  3  SHALL encode the op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 a  input  32  SHALL carry rs operand (forwarded value).
REQ-008 b  input  32  SHALL carry rt operand (forwarded value).
REQ-009 req  input  1  SHALL be the CP0 exception/interrupt request; high means the E-stage op is flushed.
REQ-010 busy  output  1  SHALL be high while a mult/div is in progress.
REQ-011 hi  output  32  SHALL expose the architectural HI register.
REQ-012 lo  output  32  SHALL expose the architectural LO register.

Function
REQ-013 States SHALL be IDLE and RUN; counter cnt SHALL be wide enough for max(MUL_LAT, DIV_LAT).
REQ-014 An op is accepted when state=IDLE, start=1, req=0 and op in 1..6; otherwise the cycle SHALL have no effect.
REQ-015 Accepting op 1-4 at edge k SHALL latch the computed 64-bit result, load cnt with the op's LAT, and enter RUN.
REQ-016 busy SHALL equal (state==RUN); it is high after edge k through edge k+LAT, i.e. exactly LAT cycles.
REQ-017 In RUN, cnt SHALL decrement each edge; at the edge where cnt goes 1->0, HI/LO SHALL take the latched result and state SHALL return to IDLE.
REQ-018 hi/lo SHALL NOT change while busy=1; a reader sees old values until the commit edge.
REQ-019 mult: signed 32x32->64, HI=[63:32], LO=[31:0]; multu: unsigned.
REQ-020 div: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend; divu: unsigned.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 Divide by zero (b=0) SHALL run the full DIV_LAT busy period and leave HI/LO unchanged.
REQ-023 mthi/mtlo accepted at edge k SHALL write a into HI/LO at edge k; busy SHALL stay 0.
REQ-024 start while busy=1 SHALL be ignored (the pipeline stalls on busy); the in-flight op SHALL complete unaffected.
REQ-025 req=1 while in RUN SHALL NOT cancel the in-flight op (it is older than the faulting instruction).
REQ-026 req=1 with start=1 in IDLE SHALL discard the op: no HI/LO write, busy stays 0.
REQ-027 Commit edge and a new start in the same cycle: the new start SHALL be ignored (state still RUN when sampled); it is accepted the following cycle.

Reset
REQ-028 reset=0 at an edge SHALL force state=IDLE, cnt=0, busy=0, hi=0, lo=0, regardless of an in-flight op; the in-flight result is discarded.
REQ-029 Reset SHALL take priority over start and req in the same cycle.

Verification
REQ-030 mult a=0xFFFFFFFF b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 div a=-7 b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7 b=2 -> lo=3, hi=1.
REQ-032 mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated on each edge, busy never high.
REQ-033 start mult with req=1 -> busy stays 0, hi/lo unchanged; req=1 on cycle 2 of a running div -> div commits normally at cycle 10.
REQ-034 div by zero with hi=0x11, lo=0x22 -> busy 10 cycles, hi=0x11, lo=0x22 afterwards; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 reset=0 on cycle 3 of a mult -> next cycle busy=0, hi=lo=0; new mult accepted the cycle after reset releases.

Source files
------------

// File: rtl/md_sched_if.sv
// E-stage side of the HI/LO multiply/divide scheduler: op request in, busy and HI/LO out.
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, req, input busy, hi, lo);
  modport slave  (input start, op, a, b, req, output busy, hi, lo);
endinterface

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler owning the architectural HI/LO registers.
// The result is computed at accept and held back until the busy period expires.
module md_sched #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_sched_if.slave bus
);
  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    res_q, res_d;
  logic           wr_q, wr_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        dvsr;
  logic signed [32:0] sa, sb;
  logic [31:0]        sq, sr, uq, ur;
  logic               accept;

  assign smul = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign umul = {32'd0, bus.a} * {32'd0, bus.b};

  // A zero divisor is swapped for 1 only to keep the dividers defined; the
  // commit is suppressed for that case, so the value never reaches HI/LO.
  // 33-bit signed division keeps 0x80000000 / -1 from overflowing.
  assign dvsr = (bus.b == 32'd0) ? 32'd1 : bus.b;
  assign sa   = $signed({bus.a[31], bus.a});
  assign sb   = $signed({dvsr[31], dvsr});
  assign sq   = 32'(sa / sb);
  assign sr   = 32'(sa % sb);
  assign uq   = bus.a / dvsr;
  assign ur   = bus.a % dvsr;

  assign accept = (state_q == IDLE) && bus.start && !bus.req &&
                  (bus.op != 3'd0) && (bus.op != 3'd7);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MULT: begin
              res_d = smul; cnt_d = CW'(MUL_LAT); wr_d = 1'b1; state_d = RUN;
            end
            OP_MULTU: begin
              res_d = umul; cnt_d = CW'(MUL_LAT); wr_d = 1'b1; state_d = RUN;
            end
            OP_DIV: begin
              res_d = {sr, sq}; cnt_d = CW'(DIV_LAT);
              wr_d  = (bus.b != 32'd0); state_d = RUN;
            end
            OP_DIVU: begin
              res_d = {ur, uq}; cnt_d = CW'(DIV_LAT);
              wr_d  = (bus.b != 32'd0); state_d = RUN;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start/req are deliberately ignored here: the in-flight op always finishes.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
